nfc_mif_wr: RTL and testbench

NFC_MIF_WR -- requirements
Module: nfc_mif_wr

---
 rtl/nfc_mif_wr_pkg.sv | 28 ++
 rtl/nfc_mif_fix.sv | 73 +++++++
 rtl/nfc_mif_wr.sv | 216 +++++++++++++++++++++
 tb/tb_nfc_mif_wr.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_mif_wr_pkg.sv
// Shared parameters for the NF_IF-to-RAM write path: data width, FSM encodings
// and ECC parity lengths.
package nfc_parameter;

  localparam int NFC_DAT_WID = 16;

  localparam logic [4:0] PAR_LEN_SHORT = 5'd14;
  localparam logic [4:0] PAR_LEN_LONG  = 5'd26;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DAT  = 3'd1,
    ST_SPA  = 3'd2,
    ST_PAR  = 3'd3,
    ST_FIX  = 3'd4
  } nfc_st_e;

  typedef enum logic [1:0] {
    FX_IDLE = 2'd0,
    FX_RD   = 2'd1,
    FX_WR   = 2'd2
  } fix_ph_e;

  function automatic logic [4:0] par_len(input logic opt);
    return opt ? PAR_LEN_LONG : PAR_LEN_SHORT;
  endfunction

endpackage

// File: rtl/nfc_mif_fix.sv
// ECC correction engine: one read-modify-write per accepted error location,
// further locations are dropped until the current one has been written back.
module nfc_mif_fix
  import nfc_parameter::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_act,
  input  logic        i_vld,
  input  logic [12:0] i_off,
  input  logic [7:0]  i_mask,
  input  logic [11:0] i_blk_len,
  input  logic [12:0] i_dat_base,
  input  logic [12:0] i_spa_base,
  input  logic [7:0]  i_rd_dat,
  output logic        o_busy,
  output logic        o_req,
  output logic        o_we,
  output logic [12:0] o_addr,
  output logic [7:0]  o_din
);

  fix_ph_e     r_ph;
  fix_ph_e     w_ph_nxt;
  logic [12:0] r_addr;
  logic [12:0] w_addr;
  logic [7:0]  r_mask;
  logic        w_take;

  assign w_take = i_act & i_vld & (r_ph == FX_IDLE);

  // Error offsets index the block's data bytes first, then its spare bytes.
  always_comb begin
    w_addr = 13'd0;
    if (i_off < {1'b0, i_blk_len}) begin
      w_addr = i_dat_base + i_off;
    end else begin
      w_addr = i_spa_base + (i_off - {1'b0, i_blk_len});
    end
  end

  always_comb begin
    w_ph_nxt = r_ph;
    case (r_ph)
      FX_IDLE: w_ph_nxt = w_take ? FX_RD : FX_IDLE;
      FX_RD:   w_ph_nxt = FX_WR;
      FX_WR:   w_ph_nxt = FX_IDLE;
      default: w_ph_nxt = FX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph   <= FX_IDLE;
      r_addr <= 13'd0;
      r_mask <= 8'd0;
    end else begin
      r_ph <= w_ph_nxt;
      if (w_take) begin
        r_addr <= w_addr;
        r_mask <= i_mask;
      end
    end
  end

  // The read goes out with the location; the write waits for RAM read data.
  assign o_busy = (r_ph != FX_IDLE);
  assign o_we   = (r_ph == FX_WR);
  assign o_req  = w_take | o_we;
  assign o_addr = o_we ? r_addr : w_addr;
  assign o_din  = i_rd_dat ^ r_mask;

endmodule

// File: rtl/nfc_mif_wr.sv
// Flash-to-RAM write path: stores data/spare bytes from NF_IF into RAM, feeds
// the ECC decoder and applies its corrections in place.
module nfc_mif_wr
  import nfc_parameter::*;
#(
  parameter int DAT_WID = NFC_DAT_WID
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        nfc_blk_len,
  input  logic [3:0]         nfc_spa_len,
  input  logic               nfc_spa_en,
  input  logic               nfc_ecc_en,
  input  logic               nfc_ecc_opt,
  input  logic [13:0]        nfc_trn_cnt,
  input  logic [13:0]        nfc_dat_addr,
  input  logic [13:0]        nfc_spa_addr,
  input  logic               nfc_dat_en,
  input  logic               nfc_dat_dir,
  input  logic               nfif_data_wr,
  input  logic [DAT_WID-1:0] nfif_data_out,
  output logic               nfif_wr_rdy,
  output logic               mif_ecc_wr,
  output logic [7:0]         mif_ecc_dat,
  input  logic               ecc_dec_vld,
  input  logic [12:0]        ecc_dec_addr,
  input  logic [7:0]         ecc_dec_mask,
  input  logic               ecc_dec_done,
  output logic [12:0]        nfc_ram_addr,
  output logic               nfc_ram_cen,
  output logic [1:0]         nfc_ram_wen,
  output logic [15:0]        nfc_ram_din,
  input  logic [15:0]        ram_nfc_dout
);

  nfc_st_e     r_state;
  nfc_st_e     w_state_nxt;
  logic        r_en_d;
  logic [11:0] r_blk_cnt;
  logic [13:0] r_trn_cnt;
  logic [13:0] r_dat_ptr;
  logic [13:0] r_spa_ptr;
  logic [12:0] r_dat_base;
  logic [12:0] r_spa_base;
  logic [13:0] w_dat_ptr_nxt;
  logic [13:0] w_spa_ptr_nxt;
  logic [11:0] w_sec_len;
  logic [7:0]  w_byte;
  logic        w_acc, w_acc_dat, w_acc_spa, w_start, w_abort;
  logic        w_sec_end, w_more, w_blk_start;
  logic        w_fix_busy, w_fix_req, w_fix_we;
  logic [12:0] w_fix_addr;
  logic [7:0]  w_fix_din;
  logic        w_unused;

  assign w_unused = ^{nfif_data_out, ram_nfc_dout[15:8]};
  assign w_byte   = nfif_data_out[7:0];

  assign nfif_wr_rdy = nfc_dat_en & ~w_fix_busy &
                       ((r_state == ST_DAT) | (r_state == ST_SPA) | (r_state == ST_PAR));
  assign w_acc     = nfif_data_wr & nfif_wr_rdy;
  assign w_acc_dat = w_acc & (r_state == ST_DAT);
  assign w_acc_spa = w_acc & (r_state == ST_SPA);
  assign w_start   = (r_state == ST_IDLE) & nfc_dat_en & ~r_en_d & ~nfc_dat_dir;
  assign w_abort   = (r_state != ST_IDLE) & ~nfc_dat_en;

  always_comb begin
    w_sec_len = 12'd0;
    case (r_state)
      ST_DAT:  w_sec_len = nfc_blk_len;
      ST_SPA:  w_sec_len = {8'd0, nfc_spa_len};
      ST_PAR:  w_sec_len = {7'd0, par_len(nfc_ecc_opt)};
      default: w_sec_len = 12'd0;
    endcase
  end

  assign w_sec_end     = w_acc & ((r_blk_cnt + 12'd1) == w_sec_len);
  assign w_more        = (r_trn_cnt + 14'd1) < nfc_trn_cnt;
  assign w_dat_ptr_nxt = r_dat_ptr + {13'd0, w_acc_dat};
  assign w_spa_ptr_nxt = r_spa_ptr + {13'd0, w_acc_spa};

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = w_start ? ST_DAT : ST_IDLE;
        ST_DAT: begin
          if (w_sec_end) begin
            w_state_nxt = nfc_spa_en ? ST_SPA :
                          nfc_ecc_en ? ST_PAR :
                          w_more     ? ST_DAT : ST_IDLE;
          end else begin
            w_state_nxt = ST_DAT;
          end
        end
        ST_SPA: begin
          if (w_sec_end) begin
            w_state_nxt = nfc_ecc_en ? ST_PAR : (w_more ? ST_DAT : ST_IDLE);
          end else begin
            w_state_nxt = ST_SPA;
          end
        end
        ST_PAR: w_state_nxt = w_sec_end ? ST_FIX : ST_PAR;
        ST_FIX: begin
          if (ecc_dec_done) begin
            w_state_nxt = (r_trn_cnt < nfc_trn_cnt) ? ST_DAT : ST_IDLE;
          end else begin
            w_state_nxt = ST_FIX;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Correction addresses are relative to the block currently being decoded.
  assign w_blk_start = (w_state_nxt == ST_DAT) & ((r_state != ST_DAT) | w_sec_end) & ~w_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_d     <= 1'b0;
      r_blk_cnt  <= 12'd0;
      r_trn_cnt  <= 14'd0;
      r_dat_ptr  <= 14'd0;
      r_spa_ptr  <= 14'd0;
      r_dat_base <= 13'd0;
      r_spa_base <= 13'd0;
    end else begin
      r_en_d <= nfc_dat_en;
      if (w_start) begin
        r_dat_ptr  <= nfc_dat_addr;
        r_spa_ptr  <= nfc_spa_addr;
        r_dat_base <= nfc_dat_addr[12:0];
        r_spa_base <= nfc_spa_addr[12:0];
        r_blk_cnt  <= 12'd0;
        r_trn_cnt  <= 14'd0;
      end else if (w_state_nxt == ST_IDLE) begin
        r_dat_ptr <= w_dat_ptr_nxt;
        r_spa_ptr <= w_spa_ptr_nxt;
        r_blk_cnt <= 12'd0;
        r_trn_cnt <= 14'd0;
      end else begin
        r_dat_ptr <= w_dat_ptr_nxt;
        r_spa_ptr <= w_spa_ptr_nxt;
        if (w_acc) begin
          r_trn_cnt <= r_trn_cnt + 14'd1;
          r_blk_cnt <= w_sec_end ? 12'd0 : r_blk_cnt + 12'd1;
        end
        if (w_blk_start) begin
          r_dat_base <= w_dat_ptr_nxt[12:0];
          r_spa_base <= w_spa_ptr_nxt[12:0];
        end
      end
    end
  end

  nfc_mif_fix u_fix (
    .clk        (clk),
    .rst        (rst),
    .i_act      (r_state == ST_FIX),
    .i_vld      (ecc_dec_vld),
    .i_off      (ecc_dec_addr),
    .i_mask     (ecc_dec_mask),
    .i_blk_len  (nfc_blk_len),
    .i_dat_base (r_dat_base),
    .i_spa_base (r_spa_base),
    .i_rd_dat   (ram_nfc_dout[7:0]),
    .o_busy     (w_fix_busy),
    .o_req      (w_fix_req),
    .o_we       (w_fix_we),
    .o_addr     (w_fix_addr),
    .o_din      (w_fix_din)
  );

  // Byte writes land one cycle after acceptance; parity bytes only reach the decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      mif_ecc_wr   <= 1'b0;
      mif_ecc_dat  <= 8'd0;
      nfc_ram_cen  <= 1'b1;
      nfc_ram_wen  <= 2'b11;
      nfc_ram_addr <= 13'd0;
      nfc_ram_din  <= 16'd0;
    end else begin
      mif_ecc_wr <= w_acc & nfc_ecc_en;
      if (w_acc & nfc_ecc_en) begin
        mif_ecc_dat <= w_byte;
      end
      if (w_acc_dat | w_acc_spa) begin
        nfc_ram_cen  <= 1'b0;
        nfc_ram_wen  <= 2'b10;
        nfc_ram_addr <= w_acc_dat ? r_dat_ptr[12:0] : r_spa_ptr[12:0];
        nfc_ram_din  <= {8'h00, w_byte};
      end else if (w_fix_req) begin
        nfc_ram_cen  <= 1'b0;
        nfc_ram_wen  <= w_fix_we ? 2'b10 : 2'b11;
        nfc_ram_addr <= w_fix_addr;
        nfc_ram_din  <= {8'h00, w_fix_din};
      end else begin
        nfc_ram_cen <= 1'b1;
        nfc_ram_wen <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_nfc_mif_wr.sv
// Randomized bench for nfc_mif_wr: RAM model plus a byte-level reference of
// where every data/spare byte should land and what the decoder should see.
module tb_nfc_mif_wr;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] nfc_blk_len;
  logic [3:0]  nfc_spa_len;
  logic        nfc_spa_en, nfc_ecc_en, nfc_ecc_opt;
  logic [13:0] nfc_trn_cnt, nfc_dat_addr, nfc_spa_addr;
  logic        nfc_dat_en, nfc_dat_dir, nfif_data_wr;
  logic [15:0] nfif_data_out;
  logic        nfif_wr_rdy, mif_ecc_wr;
  logic [7:0]  mif_ecc_dat;
  logic        ecc_dec_vld, ecc_dec_done;
  logic [12:0] ecc_dec_addr;
  logic [7:0]  ecc_dec_mask;
  logic [12:0] nfc_ram_addr;
  logic        nfc_ram_cen;
  logic [1:0]  nfc_ram_wen;
  logic [15:0] nfc_ram_din;
  logic [15:0] ram_nfc_dout;

  always #5 clk = ~clk;

  nfc_mif_wr #(.DAT_WID(16)) dut (
    .clk(clk), .rst(rst), .nfc_blk_len(nfc_blk_len), .nfc_spa_len(nfc_spa_len),
    .nfc_spa_en(nfc_spa_en), .nfc_ecc_en(nfc_ecc_en), .nfc_ecc_opt(nfc_ecc_opt),
    .nfc_trn_cnt(nfc_trn_cnt), .nfc_dat_addr(nfc_dat_addr), .nfc_spa_addr(nfc_spa_addr),
    .nfc_dat_en(nfc_dat_en), .nfc_dat_dir(nfc_dat_dir), .nfif_data_wr(nfif_data_wr),
    .nfif_data_out(nfif_data_out), .nfif_wr_rdy(nfif_wr_rdy), .mif_ecc_wr(mif_ecc_wr),
    .mif_ecc_dat(mif_ecc_dat), .ecc_dec_vld(ecc_dec_vld), .ecc_dec_addr(ecc_dec_addr),
    .ecc_dec_mask(ecc_dec_mask), .ecc_dec_done(ecc_dec_done), .nfc_ram_addr(nfc_ram_addr),
    .nfc_ram_cen(nfc_ram_cen), .nfc_ram_wen(nfc_ram_wen), .nfc_ram_din(nfc_ram_din),
    .ram_nfc_dout(ram_nfc_dout)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [15:0] mem [0:8191];
  logic [7:0]  exp_mem [0:8191];
  int          wr_cnt = 0;
  logic [7:0]  ecc_q [$];

  initial begin
    for (int a = 0; a < 8192; a++) begin
      mem[a]     = 16'h0000;
      exp_mem[a] = 8'h00;
    end
  end

  // Synchronous RAM: read data appears one cycle after a read.
  always @(posedge clk) begin
    if (!nfc_ram_cen) begin
      if (!nfc_ram_wen[0]) mem[nfc_ram_addr][7:0]  <= nfc_ram_din[7:0];
      if (!nfc_ram_wen[1]) mem[nfc_ram_addr][15:8] <= nfc_ram_din[15:8];
      if (nfc_ram_wen == 2'b11) ram_nfc_dout <= mem[nfc_ram_addr];
    end
  end

  // Observe RAM writes and decoder strobes away from the active edge.
  always @(negedge clk) begin
    if (!rst && !nfc_ram_cen && nfc_ram_wen != 2'b11) begin
      wr_cnt++;
      check_val("ram_wen", {30'd0, nfc_ram_wen}, 32'd2);
      check_val("ram_din_hi", {24'd0, nfc_ram_din[15:8]}, 32'd0);
    end
    if (!rst && mif_ecc_wr) ecc_q.push_back(mif_ecc_dat);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    logic [7:0] hi;
    n  = 0;
    hi = 8'($urandom);
    if ($urandom_range(0, 3) == 0) tick(1);
    while (!nfif_wr_rdy && n < 200) begin
      tick(1);
      n++;
    end
    if (!nfif_wr_rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL rdy_timeout: got=0 expected=1 (t=%0t)", $time);
    end else begin
      nfif_data_wr  = 1'b1;
      nfif_data_out = {hi, b};
      tick(1);
      nfif_data_wr  = 1'b0;
    end
  endtask

  task automatic do_fix(input logic [12:0] off, input logic [7:0] mask);
    ecc_dec_addr = off;
    ecc_dec_mask = mask;
    ecc_dec_vld  = 1'b1;
    tick(1);
    ecc_dec_vld  = 1'b0;
    tick(5);
  endtask

  task automatic set_cfg(input int blk, input bit spe, input int spl, input bit ecc,
                         input bit opt, input int trn, input int da, input int sa);
    nfc_blk_len  = 12'(blk);
    nfc_spa_en   = spe;
    nfc_spa_len  = 4'(spl);
    nfc_ecc_en   = ecc;
    nfc_ecc_opt  = opt;
    nfc_trn_cnt  = 14'(trn);
    nfc_dat_addr = 14'(da);
    nfc_spa_addr = 14'(sa);
    nfc_dat_dir  = 1'b0;
  endtask

  // One full transfer of nblk blocks with random corrections after each block.
  task automatic run_xfer(input int blk, input bit spe, input int spl, input bit ecc,
                          input bit opt, input int nblk, input int da, input int sa,
                          input bit fixed_pat);
    int par, sp, per_blk, trn, w0, exp_w, nc, off, addr;
    logic [7:0] b, mask;
    logic [7:0] exp_ecc [$];
    par     = ecc ? (opt ? 26 : 14) : 0;
    sp      = spe ? spl : 0;
    per_blk = blk + sp + par;
    trn     = nblk * per_blk;
    set_cfg(blk, spe, spl, ecc, opt, trn, da, sa);
    w0    = wr_cnt;
    exp_w = 0;
    ecc_q.delete();
    tick(1);
    nfc_dat_en = 1'b1;
    for (int k = 0; k < nblk; k++) begin
      for (int i = 0; i < blk; i++) begin
        b = fixed_pat ? 8'(8'hA0 + i) : 8'($urandom);
        send_byte(b);
        exp_mem[(da + k * blk + i) & 8191] = b;
        exp_ecc.push_back(b);
        exp_w++;
      end
      for (int j = 0; j < sp; j++) begin
        b = 8'($urandom);
        send_byte(b);
        exp_mem[(sa + k * sp + j) & 8191] = b;
        exp_ecc.push_back(b);
        exp_w++;
      end
      if (ecc) begin
        for (int p = 0; p < par; p++) begin
          b = 8'($urandom);
          send_byte(b);
          exp_ecc.push_back(b);
        end
        tick(3);
        check_val("rdy_in_fix", {31'd0, nfif_wr_rdy}, 32'd0);
        nc = $urandom_range(0, 2);
        for (int c = 0; c < nc; c++) begin
          off  = $urandom_range(0, blk + sp - 1);
          mask = 8'($urandom_range(1, 255));
          do_fix(13'(off), mask);
          addr = (off < blk) ? (da + k * blk + off) : (sa + k * sp + off - blk);
          exp_mem[addr & 8191] = exp_mem[addr & 8191] ^ mask;
          exp_w++;
        end
        ecc_dec_done = 1'b1;
        tick(1);
        ecc_dec_done = 1'b0;
      end
    end
    tick(4);
    check_val("rdy_after_xfer", {31'd0, nfif_wr_rdy}, 32'd0);
    nfc_dat_en = 1'b0;
    tick(2);
    check_val("ram_wr_count", 32'(wr_cnt - w0), 32'(exp_w));
    check_val("ecc_pulses", 32'(ecc_q.size()), ecc ? 32'(trn) : 32'd0);
    if (ecc && ecc_q.size() == exp_ecc.size()) begin
      for (int i = 0; i < exp_ecc.size(); i++)
        check_val("ecc_byte", {24'd0, ecc_q[i]}, {24'd0, exp_ecc[i]});
    end
    for (int k = 0; k < nblk; k++) begin
      for (int i = 0; i < blk; i++) begin
        addr = (da + k * blk + i) & 8191;
        check_val("ram_dat", {16'd0, mem[addr]}, {24'd0, exp_mem[addr]});
      end
      for (int j = 0; j < sp; j++) begin
        addr = (sa + k * sp + j) & 8191;
        check_val("ram_spa", {16'd0, mem[addr]}, {24'd0, exp_mem[addr]});
      end
    end
  endtask

  initial begin
    int w0;
    logic [7:0] sent [0:2];
    rst = 1'b1;
    nfif_data_wr = 1'b0; nfif_data_out = 16'd0; nfc_dat_en = 1'b0;
    ecc_dec_vld = 1'b0; ecc_dec_addr = 13'd0; ecc_dec_mask = 8'd0; ecc_dec_done = 1'b0;
    set_cfg(4, 1'b0, 0, 1'b0, 1'b0, 4, 32'h10, 32'h1000);
    tick(3);
    check_val("rst_rdy", {31'd0, nfif_wr_rdy}, 32'd0);
    check_val("rst_ecc_wr", {31'd0, mif_ecc_wr}, 32'd0);
    check_val("rst_ecc_dat", {24'd0, mif_ecc_dat}, 32'd0);
    check_val("rst_cen", {31'd0, nfc_ram_cen}, 32'd1);
    check_val("rst_wen", {30'd0, nfc_ram_wen}, 32'd3);
    check_val("rst_addr", {19'd0, nfc_ram_addr}, 32'd0);
    check_val("rst_din", {16'd0, nfc_ram_din}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Four plain data bytes A0..A3 at 0x10.
    run_xfer(4, 1'b0, 0, 1'b0, 1'b0, 1, 32'h10, 32'h1000, 1'b1);

    // One ECC block: 2 data + 2 spare + 14 parity, then directed corrections.
    set_cfg(2, 1'b1, 2, 1'b1, 1'b0, 18, 32'h100, 32'h1100);
    ecc_q.delete();
    tick(1);
    nfc_dat_en = 1'b1;
    send_byte(8'h11); send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    for (int p = 0; p < 14; p++) send_byte(8'(8'hC0 + p));
    tick(3);
    check_val("fix_rdy", {31'd0, nfif_wr_rdy}, 32'd0);
    check_val("fix_ecc_pulses", 32'(ecc_q.size()), 32'd18);
    if (ecc_q.size() >= 4) check_val("fix_ecc_b1", {24'd0, ecc_q[1]}, 32'h55);
    do_fix(13'd1, 8'h01);
    check_val("fix_dat1", {16'd0, mem[13'h101]}, 32'h0054);
    do_fix(13'd3, 8'h0F);
    check_val("fix_spa1", {16'd0, mem[13'h1101]}, 32'h0078);
    w0 = wr_cnt;
    ecc_dec_addr = 13'd0; ecc_dec_mask = 8'hFF; ecc_dec_vld = 1'b1;
    tick(1);
    ecc_dec_addr = 13'd2;
    tick(1);
    ecc_dec_vld = 1'b0;
    tick(6);
    check_val("b2b_writes", 32'(wr_cnt - w0), 32'd1);
    check_val("b2b_first", {16'd0, mem[13'h100]}, 32'h00EE);
    check_val("b2b_second", {16'd0, mem[13'h1100]}, 32'h0066);
    check_val("fix_rdy_hold", {31'd0, nfif_wr_rdy}, 32'd0);
    ecc_dec_done = 1'b1;
    tick(1);
    ecc_dec_done = 1'b0;
    tick(3);
    check_val("done_idle_rdy", {31'd0, nfif_wr_rdy}, 32'd0);
    nfc_dat_en = 1'b0;
    tick(2);

    // Abort after three data bytes, then restart the same transfer.
    set_cfg(8, 1'b0, 0, 1'b0, 1'b0, 8, 32'h200, 32'h1200);
    tick(1);
    w0 = wr_cnt;
    nfc_dat_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sent[i] = 8'($urandom);
      send_byte(sent[i]);
    end
    nfc_dat_en = 1'b0;
    tick(6);
    check_val("abort_writes", 32'(wr_cnt - w0), 32'd3);
    check_val("abort_rdy", {31'd0, nfif_wr_rdy}, 32'd0);
    check_val("abort_last_wr", {16'd0, mem[13'h202]}, {24'd0, sent[2]});
    run_xfer(8, 1'b0, 0, 1'b0, 1'b0, 1, 32'h200, 32'h1200, 1'b0);

    // Random configurations.
    for (int it = 0; it < 10; it++) begin
      run_xfer($urandom_range(1, 8), 1'($urandom), $urandom_range(1, 4), 1'($urandom),
               1'($urandom), $urandom_range(1, 3), $urandom_range(0, 32'h0F00),
               $urandom_range(32'h1000, 32'h1E00), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
